// File: rtl/ras_ckpt_pkg.sv
// Shared types and defaults for the checkpointed return address stack.
package ras_ckpt_pkg;

    localparam int XLEN      = 32;
    localparam int RAS_DEPTH = 8;

    typedef enum logic [1:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_SWAP
    } ras_op_e;

endpackage

// File: rtl/ras_ckpt_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module ras_ckpt_sat_counter32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != 32'hFFFF_FFFF)) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ras_ckpt.sv
// Speculation-safe circular return address stack with per-op checkpoint/restore.
// Overflow/underflow statistics counters are built only when RAS_STATS_EN is defined.
module ras_ckpt
    import ras_ckpt_pkg::*;
#(
    parameter int  DEPTH  = RAS_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CKPT_W = 2*PTR_W + 1 + XLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [XLEN-1:0]   push_addr,
    output logic [XLEN-1:0]   predicted_return,
    output logic              valid,
    output logic [CKPT_W-1:0] ckpt_out,
    input  logic              recover_en,
    input  logic [CKPT_W-1:0] recover_ckpt,
    output logic [31:0]       overflow_cnt,
    output logic [31:0]       underflow_cnt
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [XLEN-1:0]  entries [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] tos_inc;
    logic [PTR_W-1:0] rec_tos;
    logic [PTR_W:0]   rec_count;
    logic [XLEN-1:0]  rec_data;
    ras_op_e          op;

    assign tos_inc   = tos + PTR_W'(1);
    assign rec_tos   = recover_ckpt[CKPT_W-1 -: PTR_W];
    assign rec_count = recover_ckpt[XLEN +: PTR_W+1];
    assign rec_data  = recover_ckpt[XLEN-1:0];

    assign predicted_return = entries[tos];
    assign valid            = (count != '0);
    assign ckpt_out         = {tos, count, entries[tos]};

    // An empty stack turns push+pop into a plain push and a lone pop into a no-op.
    always_comb begin
        op = RAS_NONE;
        if (push && pop && (count != '0)) begin
            op = RAS_SWAP;
        end else if (push) begin
            op = RAS_PUSH;
        end else if (pop && (count != '0)) begin
            op = RAS_POP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (recover_en) begin
            tos              <= rec_tos;
            count            <= rec_count;
            entries[rec_tos] <= rec_data;
        end else begin
            case (op)
                RAS_PUSH: begin
                    tos              <= tos_inc;
                    entries[tos_inc] <= push_addr;
                    if (count != CNT_FULL) begin
                        count <= count + (PTR_W+1)'(1);
                    end
                end
                RAS_POP: begin
                    tos   <= tos - PTR_W'(1);
                    count <= count - (PTR_W+1)'(1);
                end
                RAS_SWAP: begin
                    entries[tos] <= push_addr;
                end
                default: ;
            endcase
        end
    end

`ifdef RAS_STATS_EN
    logic overflow_evt;
    logic underflow_evt;

    assign overflow_evt  = !recover_en && (op == RAS_PUSH) && (count == CNT_FULL);
    assign underflow_evt = !recover_en && pop && !push && (count == '0);

    ras_ckpt_sat_counter32 u_ovf_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (overflow_evt),
        .cnt   (overflow_cnt)
    );

    ras_ckpt_sat_counter32 u_udf_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (underflow_evt),
        .cnt   (underflow_cnt)
    );
`else
    assign overflow_cnt  = '0;
    assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed self-checking bench for ras_ckpt at DEPTH=4.
module tb_ras_ckpt;
    import ras_ckpt_pkg::*;

    localparam int D  = 4;
    localparam int PW = 2;
    localparam int CW = 2*PW + 1 + XLEN;
`ifdef RAS_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic            clk;
    logic            reset;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] push_addr;
    logic [XLEN-1:0] predicted_return;
    logic            valid;
    logic [CW-1:0]   ckpt_out;
    logic            recover_en;
    logic [CW-1:0]   recover_ckpt;
    logic [31:0]     overflow_cnt;
    logic [31:0]     underflow_cnt;

    int total = 0;
    int bad   = 0;

    ras_ckpt #(.DEPTH(D)) dut (
        .clk              (clk),
        .reset            (reset),
        .push             (push),
        .pop              (pop),
        .push_addr        (push_addr),
        .predicted_return (predicted_return),
        .valid            (valid),
        .ckpt_out         (ckpt_out),
        .recover_en       (recover_en),
        .recover_ckpt     (recover_ckpt),
        .overflow_cnt     (overflow_cnt),
        .underflow_cnt    (underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic [31:0] addr;
        logic [1:0]  tos;
        logic [2:0]  cnt;
        logic [31:0] pred;
        logic        vld;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic q, input logic [31:0] a);
        @(negedge clk);
        push      = p;
        pop       = q;
        push_addr = a;
        #1;
    endtask

    function automatic logic [CW-1:0] mk_ckpt(input logic [1:0] t, input logic [2:0] c,
                                              input logic [31:0] d);
        return {t, c, d};
    endfunction

    logic [CW-1:0] cap;

    initial begin
        // pre-operation state expected while each vector is applied
        vecs[0]  = '{1'b0, 1'b1, 32'h0,   2'd0, 3'd0, 32'h0,   1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h100, 2'd0, 3'd0, 32'h0,   1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h104, 2'd1, 3'd1, 32'h100, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h108, 2'd2, 3'd2, 32'h104, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h10C, 2'd3, 3'd3, 32'h108, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'h110, 2'd0, 3'd4, 32'h10C, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'h0,   2'd1, 3'd4, 32'h110, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'h0,   2'd0, 3'd3, 32'h10C, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 32'h0,   2'd3, 3'd2, 32'h108, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'h0,   2'd2, 3'd1, 32'h104, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h200, 2'd1, 3'd0, 32'h110, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h300, 2'd2, 3'd1, 32'h200, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 32'h400, 2'd3, 3'd2, 32'h300, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 32'h0,   2'd3, 3'd2, 32'h400, 1'b1};

        reset        = 1'b1;
        push         = 1'b0;
        pop          = 1'b0;
        push_addr    = '0;
        recover_en   = 1'b0;
        recover_ckpt = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_pred", 64'(predicted_return), 64'h0);
        check("reset_valid", 64'(valid), 64'h0);
        check("reset_ckpt", 64'(ckpt_out), 64'h0);
        check("reset_ovf", 64'(overflow_cnt), 64'h0);
        check("reset_udf", 64'(underflow_cnt), 64'h0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].push, vecs[i].pop, vecs[i].addr);
            check($sformatf("vec%0d_pred", i), 64'(predicted_return), 64'(vecs[i].pred));
            check($sformatf("vec%0d_valid", i), 64'(valid), 64'(vecs[i].vld));
            check($sformatf("vec%0d_ckpt", i), 64'(ckpt_out),
                  64'(mk_ckpt(vecs[i].tos, vecs[i].cnt, vecs[i].pred)));
        end
        check("ovf_after_table", 64'(overflow_cnt), 64'(STATS));
        check("udf_after_table", 64'(underflow_cnt), 64'(STATS));

        // checkpoint repair after a clobbering push
        drive(1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'hA0);
        drive(1'b1, 1'b0, 32'hB0);
        drive(1'b0, 1'b1, 32'h0);
        cap = ckpt_out;
        check("cap_ckpt", 64'(cap), 64'(mk_ckpt(2'd2, 3'd2, 32'hB0)));
        drive(1'b1, 1'b0, 32'hC0);
        drive(1'b0, 1'b0, 32'h0);
        check("clobber_pred", 64'(predicted_return), 64'hC0);
        @(negedge clk);
        recover_en   = 1'b1;
        recover_ckpt = cap;
        @(negedge clk);
        recover_en = 1'b0;
        #1;
        check("recover_ckpt", 64'(ckpt_out), 64'(cap));
        drive(1'b0, 1'b1, 32'h0);
        check("pop_after_rec", 64'(predicted_return), 64'hB0);
        drive(1'b0, 1'b0, 32'h0);
        check("next_top", 64'(predicted_return), 64'hA0);
        check("next_valid", 64'(valid), 64'h1);

        // recover beats a simultaneous push
        cap = ckpt_out;
        drive(1'b1, 1'b0, 32'hE0);
        @(negedge clk);
        push         = 1'b1;
        push_addr    = 32'hF0;
        recover_en   = 1'b1;
        recover_ckpt = cap;
        @(negedge clk);
        push       = 1'b0;
        recover_en = 1'b0;
        #1;
        check("rec_push_ckpt", 64'(ckpt_out), 64'(mk_ckpt(2'd1, 3'd1, 32'hA0)));

        // async reset in the middle of a push burst
        drive(1'b1, 1'b0, 32'h500);
        drive(1'b1, 1'b0, 32'h504);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_pred", 64'(predicted_return), 64'h0);
        check("async_valid", 64'(valid), 64'h0);
        check("async_ckpt", 64'(ckpt_out), 64'h0);
        check("async_udf", 64'(underflow_cnt), 64'h0);
        @(negedge clk);
        push  = 1'b0;
        reset = 1'b0;
        #1;
        check("post_reset_valid", 64'(valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
